lcd_arbiter: RTL and testbench
==============================

Name: lcd_arbiter

Overview:
- Shares the single Avalon-MM LCD_Controller slave between N_REQ requesters, for example the filter-status display and a debug/status message source.
- Each requester streams 9-bit LCD instructions, formatted as {address/RS bit, data byte}, as packets over a valid/ready handshake with a last flag.
- Arbitration is round-robin at packet boundaries. A granted packet is never interleaved with another requester's packet.
- A waitrequest watchdog aborts stuck transfers.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles inserted after each completed packet before re-arbitration (0 = none).
- TIMEOUT, 1024, maximum consecutive waitrequest-high cycles in WRITE before abort (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has an instruction beat.
- req_data  in  9*N_REQ  beat of requester i at [9i+8:9i]; bit 8 = LCD address, [7:0] = writedata.
- req_last  in  N_REQ  beat is the final one of requester i's packet.
- req_ready  out  N_REQ  beat of requester i accepted this cycle.
- grant_id  out  max(1,$clog2(N_REQ))  currently/last granted requester.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- address  out  1  Avalon address.
- chipselect  out  1  Avalon chipselect.
- byteenable  out  1  Avalon byteenable.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  8  Avalon writedata.
- waitrequest  in  1  slave stall.
- readdata  in  8  unused.
- response  in  2  unused.

Behaviour:

Reset (reset low, asynchronous):
- State = IDLE. Priority pointer selects requester 0 first; grant_id=0.
- Holding register and all counters cleared.
- All outputs 0 except byteenable.
- Reset asserted mid-write drops chipselect/write immediately. The partial packet is lost and requesters must resend.

Constant outputs:
- byteenable=1 and read=0 at all times.
- Avalon outputs are decoded from registered state/holding register only: no combinational path from waitrequest to write.

States:
- IDLE:
  - No Avalon activity; req_ready=0.
  - If any req_valid, winner = first valid requester searching from (last_grant+1) mod N_REQ upward with wrap.
  - grant_id<=winner; go to FETCH.
- FETCH:
  - req_ready[grant_id]=req_valid[grant_id]; all other ready bits 0.
  - On valid, capture data and last into the holding register; go to WRITE.
  - If the granted requester's valid is low, stay in FETCH. The grant is held until its last beat, and other requesters are not served.
- WRITE:
  - chipselect=1, write=1, address=hold[8], writedata=hold[7:0].
  - Signals remain stable while waitrequest=1; wait counter increments.
  - On waitrequest=0 the beat completes and the wait counter clears. Go to GAP if hold_last, else FETCH.
  - If the wait counter reaches TIMEOUT-1 with waitrequest still high: drop write/chipselect next cycle, pulse timeout_err, go to IDLE. last_grant is updated so the faulty requester loses priority.
- GAP:
  - Outputs inactive for GAP_CYCLES cycles; last_grant<=grant_id; then IDLE.
  - With GAP_CYCLES=0, WRITE goes directly to IDLE.

Latency:
- req_valid rising in IDLE at cycle t: grant at t+1, req_ready at t+1, write asserted at t+2.
- Each subsequent beat costs 2 cycles (FETCH+WRITE) plus waitrequest stall cycles.

Boundary conditions:
- Simultaneous valids: the round-robin pointer decides.
- A new request during GAP is not granted until IDLE.
- A single-beat packet (last on first beat) is legal.
- grant_id holds its value in IDLE.

Test Plan:
- Single packet: req0 sends {CLEAR_DISPLAY, 'F'} with last on 'F', waitrequest=0 → two writes: (address=0, writedata=0x01) then (address=1, writedata=0x46); write first high 2 cycles after valid; then GAP 2 cycles; busy low afterwards.
- Fairness: req0 and req1 both continuously valid with 3-beat packets → packets granted in order 1?0: first grant is req0 (pointer reset), then req1, req0, req1; no interleaving of beats.
- Stall: waitrequest held high for 5 cycles on the second beat → address/writedata/write stable all 5 cycles; beat completes in the cycle waitrequest falls; no timeout_err.
- Requester gap: req1 granted, drops valid for 4 cycles mid-packet while req0 is valid → arbiter stays in FETCH on req1, req_ready[0]=0 throughout, resumes req1 on valid.
- Watchdog: TIMEOUT=8, waitrequest stuck high → write drops after 8 stall cycles; timeout_err is a single-cycle pulse; the next grant goes to the other requester.
- Async reset mid-WRITE: reset low while write=1 → write, chipselect, busy and req_ready go 0 without a clock edge; after release, the first grant is req0.

Source files
------------

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM LCD controller slave between N_REQ packet streams.
// Packets are never interleaved; a waitrequest watchdog aborts transfers that stall too long.
module lcd_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [N_REQ-1:0]                              req_valid,
    input  logic [9*N_REQ-1:0]                            req_data,
    input  logic [N_REQ-1:0]                              req_last,
    output logic [N_REQ-1:0]                              req_ready,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]  grant_id,
    output logic                                          busy,
    output logic                                          timeout_err,
    output logic                                          address,
    output logic                                          chipselect,
    output logic                                          byteenable,
    output logic                                          read,
    output logic                                          write,
    output logic [7:0]                                    writedata,
    input  logic                                          waitrequest,
    input  logic [7:0]                                    readdata,
    input  logic [1:0]                                    response
);

    localparam int unsigned GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GPW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned WAIT_LAST = TIMEOUT - 1;
    localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StFetch, StWrite, StGap} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [8:0]      hold_data_q, hold_data_d;
    logic            hold_last_q, hold_last_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [GPW-1:0]  gap_q, gap_d;
    logic            terr_q, terr_d;

    logic [8:0]      beat [N_REQ];
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            found;

    // The controller's read path is never used.
    logic unused_inputs;
    assign unused_inputs = ^{readdata, response};

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            beat[i] = req_data[9*i +: 9];
        end
    end

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        winner = grant_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = GW'((32'(last_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= GW'(N_REQ - 1);
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            wait_q      <= '0;
            gap_q       <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        wait_d      = wait_q;
        gap_d       = gap_q;
        terr_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (req_valid[grant_q]) begin
                    hold_data_d = beat[grant_q];
                    hold_last_d = req_last[grant_q];
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (!waitrequest) begin
                    wait_d = '0;
                    if (hold_last_q) begin
                        last_d = grant_q;
                        gap_d  = '0;
                        state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (wait_q == WW'(WAIT_LAST)) begin
                    // Abort; the stuck requester drops to lowest priority.
                    wait_d  = '0;
                    last_d  = grant_q;
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GPW'(GAP_LAST)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StFetch) begin
            req_ready[grant_q] = req_valid[grant_q];
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = terr_q;
    assign chipselect  = (state_q == StWrite);
    assign write       = (state_q == StWrite);
    assign address     = (state_q == StWrite) & hold_data_q[8];
    assign writedata   = (state_q == StWrite) ? hold_data_q[7:0] : 8'h00;
    assign byteenable  = 1'b1;
    assign read        = 1'b0;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: directed latency/stall/watchdog/reset cases plus
// randomized packet rounds checked against a packet-level round-robin model.
module tb_lcd_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [9*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [0:0]     grant_id;
    logic           busy, timeout_err, address, chipselect, byteenable, read, write;
    logic [7:0]     writedata;
    logic           waitrequest;
    logic [7:0]     readdata = 8'h00;
    logic [1:0]     response = 2'b00;

    logic           tb_valid [N];
    logic [8:0]     tb_data [N];
    logic           tb_last [N];

    logic wr_rand = 1'b0;
    logic wr_force = 1'b0;
    logic wr_rnd_val = 1'b0;
    int   stall_run = 0;

    int checks = 0;
    int errors = 0;
    int model_last = N - 1;

    logic [9:0] beats_q [N][$];  // {last, address, data}
    logic [9:0] exp_q [$];       // {requester, address, data}

    lcd_arbiter #(.N_REQ(N), .GAP_CYCLES(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .address(address), .chipselect(chipselect), .byteenable(byteenable), .read(read),
        .write(write), .writedata(writedata), .waitrequest(waitrequest),
        .readdata(readdata), .response(response)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = tb_valid[i];
            req_data[9*i +: 9] = tb_data[i];
            req_last[i]        = tb_last[i];
        end
    end

    assign waitrequest = wr_rand ? wr_rnd_val : wr_force;

    // Random stalls, never long enough to trip the watchdog.
    always @(posedge clk) begin
        #1;
        if (stall_run >= 3) wr_rnd_val = 1'b0;
        else wr_rnd_val = ($urandom_range(0, 2) == 0);
        stall_run = wr_rnd_val ? stall_run + 1 : 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed Avalon write is popped from the scoreboard.
    always @(negedge clk) begin
        logic [9:0] act;
        if (rst_n) begin
            check("const_outputs", {30'b0, byteenable, read}, 32'h2);
            if (req_ready != '0) begin
                check("ready_only_granted", {30'b0, req_ready & ~(N'(1) << grant_id)}, 32'h0);
            end
            if (write && chipselect && !waitrequest) begin
                act = {grant_id[0], address, writedata};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none", act);
                end else begin
                    check("write_beat", {22'b0, act}, {22'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic drive(input int r);
        bit first = 1'b1;
        while (beats_q[r].size() > 0) begin
            logic [9:0] b;
            int budget;
            bit got;
            b = beats_q[r].pop_front();
            if (!first && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            tb_valid[r] = 1'b1;
            tb_data[r]  = b[8:0];
            tb_last[r]  = b[9];
            budget = 300;
            got = 1'b0;
            while (budget > 0 && !got) begin
                @(negedge clk);
                if (req_ready[r]) got = 1'b1;
                else budget--;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: requester %0d got no ready, required ready", r);
                tb_valid[r] = 1'b0;
                beats_q[r].delete();
                return;
            end
            @(posedge clk);
            #1;
            tb_valid[r] = 1'b0;
            first = b[9];
        end
    endtask

    // Packet-level reference: whole packets served round-robin among requesters with work left.
    task automatic model_plan();
        int pos [N];
        for (int i = 0; i < N; i++) pos[i] = 0;
        forever begin
            int pick;
            logic [9:0] b;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int r;
                r = (model_last + k) % N;
                if (pick < 0 && pos[r] < beats_q[r].size()) pick = r;
            end
            if (pick < 0) break;
            do begin
                b = beats_q[pick][pos[pick]];
                pos[pick]++;
                exp_q.push_back({1'(pick), b[8:0]});
            end while (!b[9]);
            model_last = pick;
        end
    endtask

    task automatic wait_for_write(input string name);
        int n = 0;
        while (!write && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!write) begin
            errors++;
            $display("FAIL %s: write low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: busy=%0d pending=%0d, required 0 and 0", name, busy, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            tb_valid[i] = 1'b0;
            tb_data[i]  = '0;
            tb_last[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, timeout_err, address, chipselect, read, write, writedata,
                                req_ready, grant_id}, 32'h0);
        check("reset_byteenable", {31'b0, byteenable}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Single packet: CLEAR_DISPLAY then 'F'.
        exp_q.push_back({1'b0, 9'h001});
        exp_q.push_back({1'b0, 9'h146});
        tb_valid[0] = 1'b1; tb_data[0] = 9'h001; tb_last[0] = 1'b0;
        check("idle_not_busy", {31'b0, busy}, 32'h0);
        tick();
        check("t1_grant_ready_nowrite", {grant_id, req_ready, write}, {1'b0, 2'b01, 1'b0});
        tick();
        tb_data[0] = 9'h146; tb_last[0] = 1'b1;
        check("t2_write_beat0", {write, chipselect, address, writedata}, {3'b110, 8'h01});
        tick();
        check("t3_ready_beat1", {30'b0, req_ready}, 32'h1);
        tick();
        tb_valid[0] = 1'b0;
        check("t4_write_beat1", {write, chipselect, address, writedata}, {3'b111, 8'h46});
        tick();
        check("gap1_busy_nowrite", {busy, write}, 2'b10);
        tick();
        check("gap2_busy", {31'b0, busy}, 32'h1);
        tick();
        check("after_gap_idle", {31'b0, busy}, 32'h0);
        model_last = 0;

        // Stall on the second beat for 5 cycles.
        beats_q[0].push_back(10'h038);
        beats_q[0].push_back(10'h341);
        exp_q.push_back({1'b0, 9'h038});
        exp_q.push_back({1'b0, 9'h141});
        fork drive(0); join_none
        wait_for_write("stall_first_write");
        tick();
        wr_force = 1'b1;
        wait_for_write("stall_second_write");
        for (int i = 0; i < 5; i++) begin
            check("stall_stable", {timeout_err, write, chipselect, address, writedata},
                  {4'b0111, 8'h41});
            tick();
        end
        wr_force = 1'b0;
        check("stall_release_write", {timeout_err, write, address}, 3'b011);
        tick();
        check("stall_done", {timeout_err, write, busy}, 3'b001);
        wait fork;
        wait_idle("stall_idle");

        // Watchdog: requester 1 is next in turn and its beat never completes.
        wr_force = 1'b1;
        beats_q[1].push_back(10'h20C);
        beats_q[0].push_back(10'h280);
        exp_q.push_back({1'b0, 9'h080});
        fork drive(0); drive(1); join_none
        wait_for_write("wd_start");
        check("wd_grant", {31'b0, grant_id}, 32'h1);
        n = 0;
        while (write && n < 20) begin
            n++;
            tick();
        end
        check("wd_write_cycles", n, 8);
        check("wd_pulse", {31'b0, timeout_err}, 32'h1);
        wr_force = 1'b0;
        tick();
        check("wd_pulse_single_next_grant", {timeout_err, grant_id}, 2'b00);
        wait fork;
        wait_idle("wd_idle");
        model_last = 0;

        // Asynchronous reset in the middle of a write.
        wr_force = 1'b1;
        tb_valid[0] = 1'b1; tb_data[0] = 9'h155; tb_last[0] = 1'b0;
        wait_for_write("rst_start");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {write, chipselect, busy, req_ready}, 5'b0);
        tb_valid[0] = 1'b0;
        wr_force = 1'b0;
        tick();
        rst_n = 1'b1;
        model_last = N - 1;
        beats_q[0].push_back(10'h255);
        beats_q[1].push_back(10'h266);
        model_plan();
        fork drive(0); drive(1); join_none
        tick();
        check("rst_first_grant", {grant_id, req_ready}, {1'b0, 2'b01});
        wait fork;
        wait_idle("rst_idle");

        // Randomized rounds with random stalls and mid-packet valid gaps.
        wr_rand = 1'b1;
        for (int round = 0; round < 25; round++) begin
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    int nb;
                    nb = $urandom_range(1, 3);
                    for (int j = 0; j < nb; j++) begin
                        beats_q[r].push_back({(j == nb - 1), 9'($urandom)});
                    end
                end
            end
            model_plan();
            fork drive(0); drive(1); join
            wait_idle("random_round_idle");
        end
        wr_rand = 1'b0;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
